// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO draining into the UART transmitter over tx_load/tx_data/tx_ready
//
// Purpose:
//   Circular byte buffer written by the I/O side one byte per wr_en cycle and
//   drained one byte at a time into the transmitter. A three-state drain FSM
//   (IDLE -> LOAD -> HOLD) issues a one-cycle tx_load pulse. It then waits out
//   the transmitter's one-cycle tx_ready drop latency, so that no byte is
//   loaded twice.
//
// Optional feature (macro UART_TX_FIFO_OVF_EN):
//   Adds a sticky overflow flag ovf, set by a write while full and cleared by
//   ovf_clr. When both happen on the same edge, the set wins. When the macro is
//   undefined, dropped writes are silent and the ovf/ovf_clr ports do not exist.
//
// Ports:
//   clk       in   system clock, rising edge
//   nrst      in   asynchronous active-low reset
//   wr_en     in   write strobe, one byte per cycle high
//   wr_data   in   byte to enqueue
//   full      out  FIFO holds 2**DEPTH_LOG2 entries
//   empty     out  FIFO holds 0 entries
//   count     out  occupancy 0..2**DEPTH_LOG2
//   tx_load   out  one-cycle pulse: tx_data valid, start a frame
//   tx_data   out  registered byte for the transmitter, held until next load
//   tx_ready  in   transmitter idle and able to accept a byte
//   ovf       out  sticky overflow flag (UART_TX_FIFO_OVF_EN only)
//   ovf_clr   in   clears ovf (UART_TX_FIFO_OVF_EN only)

module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  tx_load,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                  ovf,
  input  logic                  ovf_clr
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    tx_load_q, tx_load_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    push;
  logic                    pop;

  // Flags decode the registered count, so a write while full is dropped even
  // when a pop frees a slot on the same edge.
  assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign tx_load = tx_load_q;
  assign tx_data = tx_data_q;

  assign push = wr_en & ~full;

  // Drain FSM: a pop is only taken from IDLE. LOAD and HOLD are the two dead
  // cycles that let the transmitter deassert tx_ready after seeing tx_load.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && tx_ready) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_load_d = pop;
    tx_data_d = tx_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end
    if (push && !pop) begin
      count_d = count_q + (DEPTH_LOG2+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_load_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_load_q <= tx_load_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Storage is not reset; only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a queue-based model
module tb_uart_tx_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          tx_ready = 1'b0;
  logic          full, empty, tx_load;
  logic [DL:0]   count;
  logic [7:0]    tx_data;
`ifdef UART_TX_FIFO_OVF_EN
  logic          ovf;
  logic          ovf_clr = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  // 0: ready low, 1: ready high, 2: transmitter model, 3: random
  int tx_mode = 3;

  // Model state: queued bytes, load cooldown, expected outputs.
  byte unsigned mq[$];
  int           m_gap = 0;
  bit           m_load = 1'b0;
  byte unsigned m_data = 8'h00;
  bit           m_ovf = 1'b0;

  byte unsigned log_data[$];
  int           log_cyc[$];

  uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a byte may be handed over at most once every 3 edges, and only
  // when a byte was queued before the edge and tx_ready is high.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!nrst) begin
      mq.delete();
      m_gap  = 0;
      m_load = 1'b0;
      m_data = 8'h00;
      m_ovf  = 1'b0;
    end else begin
      bit was_full;
      was_full = (mq.size() == DEPTH);
      m_load = 1'b0;
      if (m_gap > 0) begin
        m_gap--;
      end else if (mq.size() != 0 && tx_ready) begin
        m_data = mq.pop_front();
        m_load = 1'b1;
        m_gap  = 2;
      end
      if (wr_en && !was_full) mq.push_back(wr_data);
`ifdef UART_TX_FIFO_OVF_EN
      if (wr_en && was_full) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
`endif
    end
  end

  // Per-cycle compare against the model, plus a log of observed loads.
  initial forever begin
    @(negedge clk);
    #2;
    if (!nrst) begin
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_tx_load", tx_load, 0);
      chk("rst_tx_data", tx_data, 0);
`ifdef UART_TX_FIFO_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
    end else begin
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("tx_load", tx_load, m_load);
      chk("tx_data", tx_data, m_data);
`ifdef UART_TX_FIFO_OVF_EN
      chk("ovf", ovf, m_ovf);
`endif
      if (tx_load === 1'b1) begin
        log_data.push_back(tx_data);
        log_cyc.push_back(cyc);
      end
    end
  end

  // Transmitter-side driver for tx_ready.
  initial begin
    int busy;
    busy = 0;
    forever begin
      @(negedge clk);
      #1;
      case (tx_mode)
        0: tx_ready = 1'b0;
        1: tx_ready = 1'b1;
        2: begin
          if (tx_load === 1'b1) busy = 5;
          tx_ready = (busy == 0);
          if (busy > 0) busy--;
        end
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  task automatic push(input byte unsigned d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
  endtask

  initial begin
    int n0;
    int ws;
    // Reset with random inputs, then release.
    repeat (4) begin
      @(negedge clk);
      wr_en   = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    wr_en   = 1'b0;
    tx_mode = 0;
    nrst    = 1'b1;
    idle(3);
    #2;
    chk("post_rst_count", count, 0);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_tx_data", tx_data, 0);

    // Single byte: load two clocks after the write.
    @(negedge clk);
    tx_mode = 1;
    n0 = log_data.size();
    push(8'h41);
    ws = cyc;
    idle(6);
    #2;
    chk("single_nloads", log_data.size() - n0, 1);
    chk("single_data", log_data[n0], 8'h41);
    chk("single_latency", log_cyc[n0] - ws, 2);
    chk("single_count", count, 0);

    // Ordering under backpressure.
    @(negedge clk);
    tx_mode = 0;
    n0 = log_data.size();
    push(8'h55);
    push(8'hAA);
    push(8'h0F);
    idle(3);
    #2;
    chk("bp_count", count, 3);
    chk("bp_noload", log_data.size() - n0, 0);
    @(negedge clk);
    tx_mode = 2;
    idle(40);
    #2;
    chk("ord_n", log_data.size() - n0, 3);
    chk("ord_0", log_data[n0], 8'h55);
    chk("ord_1", log_data[n0+1], 8'hAA);
    chk("ord_2", log_data[n0+2], 8'h0F);
    chk("ord_gap01", (log_cyc[n0+1] - log_cyc[n0]) >= 3, 1);
    chk("ord_gap12", (log_cyc[n0+2] - log_cyc[n0+1]) >= 3, 1);

    // Full, dropped write, overflow, drain, second fill across the wrap.
    for (int pass = 0; pass < 2; pass++) begin
      byte unsigned base;
      base = (pass == 0) ? 8'h00 : 8'h80;
      @(negedge clk);
      tx_mode = 0;
      for (int i = 0; i < 17; i++) push(8'(base + i));
      idle(2);
      #2;
      chk("fill_count", count, 16);
      chk("fill_full", full, 1);
`ifdef UART_TX_FIFO_OVF_EN
      chk("fill_ovf", ovf, 1);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      #2;
      chk("ovf_cleared", ovf, 0);
`endif
      n0 = log_data.size();
      @(negedge clk);
      tx_mode = 1;
      idle(60);
      #2;
      chk("drain_n", log_data.size() - n0, 16);
      for (int i = 0; i < 16; i++) chk("drain_byte", log_data[n0+i], 32'(8'(base + i)));
      chk("drain_empty", empty, 1);
    end

    // Simultaneous write and pop at count 5.
    @(negedge clk);
    tx_mode = 0;
    for (int i = 0; i < 5; i++) push(8'(8'h21 + i));
    idle(2);
    #2;
    chk("sim_pre_count", count, 5);
    n0 = log_data.size();
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h26;
    tx_mode = 1;
    @(negedge clk);
    wr_en   = 1'b0;
    tx_mode = 0;
    #2;
    chk("sim_count", count, 5);
    chk("sim_load", tx_load, 1);
    idle(3);
    tx_mode = 1;
    idle(25);
    #2;
    chk("sim_n", log_data.size() - n0, 6);
    for (int i = 0; i < 6; i++) chk("sim_order", log_data[n0+i], 32'(8'(8'h21 + i)));

    // Reset during LOAD with three bytes still queued.
    @(negedge clk);
    tx_mode = 0;
    for (int i = 0; i < 4; i++) push(8'(8'h31 + i));
    idle(2);
    @(negedge clk);
    tx_mode = 1;
    @(posedge clk);
    #1;
    chk("mid_count", count, 3);
    chk("mid_load", tx_load, 1);
    @(negedge clk);
    tx_mode = 0;
    nrst    = 1'b0;
    #2;
    chk("mid_rst_load", tx_load, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    idle(2);
    nrst    = 1'b1;
    tx_mode = 1;
    n0 = log_data.size();
    idle(10);
    #2;
    chk("mid_no_loads", log_data.size() - n0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
